// File: rtl/wishbone_master_xactor.sv
// wishbone_master_xactor: Wishbone B4 pipelined master. Client requests come in
// through a put interface and go out as pipelined Wishbone cycles. One response
// per request comes back, in order, through a get interface.
// Ports: CLK/RST (sync, active-high); client_request_put {we,sel,adr,dat} with EN/RDY;
// client_response_get (captured DAT_I) with EN/RDY; Wishbone CYC/STB/WE/ADR/SEL/DAT_O
// out, STALL/ACK/DAT_I in.
module wishbone_master_xactor #(
    parameter int REQ_DEPTH  = 2,
    parameter int RESP_DEPTH = 8
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic [68:0] client_request_put,
    input  logic        EN_client_request_put,
    output logic        RDY_client_request_put,
    input  logic        EN_client_response_get,
    output logic [31:0] client_response_get,
    output logic        RDY_client_response_get,
    output logic        CYC_O,
    output logic        STB_O,
    output logic        WE_O,
    output logic [31:0] ADR_O,
    output logic [3:0]  SEL_O,
    output logic [31:0] DAT_O,
    input  logic        STALL_I,
    input  logic        ACK_I,
    input  logic [31:0] DAT_I
);
    localparam int QA = $clog2(REQ_DEPTH);
    localparam int QC = $clog2(REQ_DEPTH + 1);
    localparam int RA = $clog2(RESP_DEPTH);
    localparam int RC = $clog2(RESP_DEPTH + 1);

    logic [68:0] r_req [REQ_DEPTH];
    logic [QA-1:0] r_req_wp, r_req_rp;
    logic [QC-1:0] r_req_cnt;
    logic [31:0] r_resp [RESP_DEPTH];
    logic [RA-1:0] r_resp_wp, r_resp_rp;
    logic [RC-1:0] r_resp_cnt;
    logic [RC-1:0] r_out;
    logic r_rst_d;

    logic w_req_ne, w_credit, w_enq, w_issue, w_ack, w_deq;
    logic [RC:0] w_sum;
    logic [68:0] w_cur;

    // Every issued request reserves a response slot, so an ACK always has room.
    assign w_sum    = {1'b0, r_out} + {1'b0, r_resp_cnt};
    assign w_credit = w_sum < (RC+1)'(RESP_DEPTH);
    assign w_req_ne = r_req_cnt != '0;
    assign w_cur    = w_req_ne ? r_req[r_req_rp] : '0;

    assign CYC_O = !RST && (w_req_ne || r_out != '0);
    assign STB_O = !RST && w_req_ne && w_credit;
    assign WE_O  = w_cur[68];
    assign SEL_O = w_cur[67:64];
    assign ADR_O = w_cur[63:32];
    assign DAT_O = w_cur[31:0];

    // Both RDYs stay low during reset and for the first cycle after it.
    assign RDY_client_request_put  = !RST && !r_rst_d && r_req_cnt != QC'(REQ_DEPTH);
    assign RDY_client_response_get = !RST && !r_rst_d && r_resp_cnt != '0;
    assign client_response_get     = r_resp[r_resp_rp];

    assign w_enq   = EN_client_request_put && RDY_client_request_put;
    assign w_issue = STB_O && !STALL_I;
    assign w_ack   = ACK_I && r_out != '0;
    assign w_deq   = EN_client_response_get && RDY_client_response_get;

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_req_wp   <= '0;
            r_req_rp   <= '0;
            r_req_cnt  <= '0;
            r_resp_wp  <= '0;
            r_resp_rp  <= '0;
            r_resp_cnt <= '0;
            r_out      <= '0;
            r_rst_d    <= 1'b1;
        end else begin
            r_rst_d <= 1'b0;
            if (w_enq) begin
                r_req[r_req_wp] <= client_request_put;
                r_req_wp        <= r_req_wp + QA'(1);
            end
            if (w_issue) r_req_rp <= r_req_rp + QA'(1);
            r_req_cnt <= r_req_cnt + QC'(w_enq) - QC'(w_issue);
            if (w_ack) begin
                r_resp[r_resp_wp] <= DAT_I;
                r_resp_wp         <= r_resp_wp + RA'(1);
            end
            if (w_deq) r_resp_rp <= r_resp_rp + RA'(1);
            r_resp_cnt <= r_resp_cnt + RC'(w_ack) - RC'(w_deq);
            r_out      <= r_out + RC'(w_issue) - RC'(w_ack);
        end
    end
endmodule

// File: tb/tb_wishbone_master_xactor.sv
// tb_wishbone_master_xactor: self-checking bench for wishbone_master_xactor.
module tb_wishbone_master_xactor;
    logic        CLK = 0;
    logic        RST;
    logic [68:0] client_request_put;
    logic        EN_client_request_put;
    logic        RDY_client_request_put;
    logic        EN_client_response_get;
    logic [31:0] client_response_get;
    logic        RDY_client_response_get;
    logic        CYC_O, STB_O, WE_O;
    logic [31:0] ADR_O, DAT_O;
    logic [3:0]  SEL_O;
    logic        STALL_I, ACK_I;
    logic [31:0] DAT_I;

    wishbone_master_xactor #(.REQ_DEPTH(2), .RESP_DEPTH(8)) dut (
        .CLK(CLK), .RST(RST),
        .client_request_put(client_request_put),
        .EN_client_request_put(EN_client_request_put),
        .RDY_client_request_put(RDY_client_request_put),
        .EN_client_response_get(EN_client_response_get),
        .client_response_get(client_response_get),
        .RDY_client_response_get(RDY_client_response_get),
        .CYC_O(CYC_O), .STB_O(STB_O), .WE_O(WE_O), .ADR_O(ADR_O),
        .SEL_O(SEL_O), .DAT_O(DAT_O),
        .STALL_I(STALL_I), .ACK_I(ACK_I), .DAT_I(DAT_I)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic        we;
        logic [3:0]  sel;
        logic [31:0] adr;
        logic [31:0] dat;
        logic [31:0] exp;
    } req_t;

    typedef struct {
        logic        we;
        logic [3:0]  sel;
        logic [31:0] adr;
        logic [31:0] dat;
        logic [31:0] exp;
        int          lat;
        int          nstall;
    } vec_t;

    typedef struct {
        int          due;
        logic [31:0] dat;
    } ack_t;

    req_t        pend[$];
    logic [31:0] sb[$];
    ack_t        ack_q[$];
    int cyc = 0, issues = 0, strobes = 0, checks = 0, errors = 0;
    int lat_v = 1, deq_budget = -1;
    logic stall_v = 0, force_ack = 0;

    // Slave memory model: reads of 0x100 return a signature, others adr/4.
    function automatic logic [31:0] rd_data(logic [31:0] a);
        return (a == 32'h100) ? 32'hDEADBEEF : (a >> 2);
    endfunction

    task automatic chk(string n, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got=%h expected=%h", n, act, exp);
        end
    endtask

    // One cycle: client get/put, slave ack pipeline, issue monitor.
    task automatic tick();
        req_t r;
        ack_t a;
        @(negedge CLK);
        cyc++;
        if (RDY_client_response_get && deq_budget != 0) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_resp: got=%h expected=none", client_response_get);
            end else chk("resp", client_response_get, sb.pop_front());
            EN_client_response_get = 1;
            if (deq_budget > 0) deq_budget--;
        end else EN_client_response_get = 0;
        if (pend.size() != 0 && RDY_client_request_put) begin
            r = pend.pop_front();
            client_request_put = {r.we, r.sel, r.adr, r.dat};
            EN_client_request_put = 1;
            sb.push_back(r.exp);
        end else EN_client_request_put = 0;
        STALL_I = stall_v;
        if (ack_q.size() != 0 && ack_q[0].due <= cyc) begin
            a = ack_q.pop_front();
            ACK_I = 1;
            DAT_I = a.dat;
        end else begin
            ACK_I = force_ack;
            DAT_I = force_ack ? 32'h55 : 32'h0;
        end
        if (STB_O) strobes++;
        if (STB_O && !STALL_I) begin
            issues++;
            ack_q.push_back('{cyc + lat_v, rd_data(ADR_O)});
        end
    endtask

    task automatic drain(string n, int bound);
        int k = 0;
        while ((pend.size() != 0 || sb.size() != 0 || CYC_O) && k < bound) begin
            tick();
            k++;
        end
        chk(n, 32'(k < bound), 32'd1);
    endtask

    task automatic run_one(vec_t v);
        int i0 = issues;
        lat_v = v.lat;
        stall_v = 0;
        pend.push_back('{v.we, v.sel, v.adr, v.dat, v.exp});
        tick();
        for (int k = 0; k <= v.nstall; k++) begin
            stall_v = (k < v.nstall);
            tick();
            chk("vec_stb", 32'(STB_O), 32'd1);
            chk("vec_adr", ADR_O, v.adr);
            chk("vec_sel", 32'(SEL_O), 32'(v.sel));
            chk("vec_dat", DAT_O, v.dat);
            chk("vec_we", 32'(WE_O), 32'(v.we));
        end
        stall_v = 0;
        for (int k = 0; k < v.lat; k++) begin
            tick();
            chk("vec_cyc_hold", 32'(CYC_O), 32'd1);
        end
        tick();
        chk("vec_cyc_drop", 32'(CYC_O), 32'd0);
        chk("vec_resp_rdy", 32'(RDY_client_response_get), 32'd1);
        chk("vec_sb_empty", 32'(sb.size()), 32'd0);
        tick();
        chk("vec_one_issue", 32'(issues - i0), 32'd1);
        chk("vec_resp_gone", 32'(RDY_client_response_get), 32'd0);
    endtask

    vec_t vecs[4];

    initial begin
        int i0, s0, n, first, last, rises;
        logic prev_cyc, bad;
        vecs[0] = '{1'b0, 4'hF, 32'h100,  32'h0,        32'hDEADBEEF, 1, 0};
        vecs[1] = '{1'b1, 4'h3, 32'h40,   32'h1234,     32'h10,       1, 3};
        vecs[2] = '{1'b1, 4'h1, 32'h8,    32'hA5A5A5A5, 32'h2,        3, 1};
        vecs[3] = '{1'b0, 4'hC, 32'h1000, 32'h0,        32'h400,      2, 0};

        RST = 1;
        client_request_put = '0;
        EN_client_request_put = 0;
        EN_client_response_get = 0;
        STALL_I = 0;
        ACK_I = 0;
        DAT_I = '0;
        tick();
        tick();
        chk("rst_cyc", 32'(CYC_O), 32'd0);
        chk("rst_stb", 32'(STB_O), 32'd0);
        chk("rst_rdy_put", 32'(RDY_client_request_put), 32'd0);
        chk("rst_rdy_get", 32'(RDY_client_response_get), 32'd0);
        RST = 0;
        #1;
        chk("post_rst_rdy_put", 32'(RDY_client_request_put), 32'd0);
        chk("post_rst_cyc", 32'(CYC_O), 32'd0);
        tick();
        chk("idle_rdy_put", 32'(RDY_client_request_put), 32'd1);
        chk("idle_rdy_get", 32'(RDY_client_response_get), 32'd0);

        foreach (vecs[i]) run_one(vecs[i]);

        // Pipelined burst of 8 reads with ACKs two cycles after issue.
        lat_v = 2;
        i0 = issues;
        s0 = strobes;
        for (int i = 0; i < 8; i++) pend.push_back('{1'b0, 4'hF, 32'(i * 4), 32'h0, 32'(i)});
        first = 0;
        last = 0;
        rises = 0;
        prev_cyc = 0;
        n = 0;
        while ((pend.size() != 0 || sb.size() != 0 || CYC_O) && n < 60) begin
            tick();
            n++;
            if (CYC_O && !prev_cyc) rises++;
            prev_cyc = CYC_O;
            if (STB_O) begin
                if (first == 0) first = cyc;
                last = cyc;
            end
        end
        chk("burst_done", 32'(n < 60), 32'd1);
        chk("burst_issues", 32'(issues - i0), 32'd8);
        chk("burst_strobes", 32'(strobes - s0), 32'd8);
        chk("burst_contig", 32'(last - first), 32'd7);
        chk("burst_cyc_rises", 32'(rises), 32'd1);

        // Credit backpressure: client holds off dequeuing.
        lat_v = 1;
        deq_budget = 0;
        i0 = issues;
        for (int i = 0; i < 10; i++) pend.push_back('{1'b0, 4'hF, 32'(i * 4), 32'h0, 32'(i)});
        repeat (30) tick();
        chk("credit_issues", 32'(issues - i0), 32'd8);
        chk("credit_stb", 32'(STB_O), 32'd0);
        chk("credit_cyc", 32'(CYC_O), 32'd1);
        chk("credit_rdy_get", 32'(RDY_client_response_get), 32'd1);
        deq_budget = 1;
        repeat (10) tick();
        chk("credit_one_more", 32'(issues - i0), 32'd9);
        deq_budget = -1;
        drain("credit_drain", 80);
        chk("credit_total", 32'(issues - i0), 32'd10);

        // Reset with three requests outstanding; their late ACKs must be dropped.
        lat_v = 5;
        i0 = issues;
        for (int i = 0; i < 3; i++) pend.push_back('{1'b0, 4'hF, 32'h200 + 32'(i * 4), 32'h0, 32'h0});
        n = 0;
        while (issues - i0 < 3 && n < 40) begin
            tick();
            n++;
        end
        chk("rst_mid_issued", 32'(issues - i0), 32'd3);
        RST = 1;
        sb.delete();
        #1;
        chk("rst_mid_cyc", 32'(CYC_O), 32'd0);
        chk("rst_mid_stb", 32'(STB_O), 32'd0);
        tick();
        RST = 0;
        #1;
        chk("rst_mid_rdy_put", 32'(RDY_client_request_put), 32'd0);
        chk("rst_mid_rdy_get", 32'(RDY_client_response_get), 32'd0);
        bad = 0;
        repeat (10) begin
            tick();
            if (RDY_client_response_get || CYC_O) bad = 1;
        end
        chk("late_ack_ignored", 32'(bad), 32'd0);
        chk("late_acks_sent", 32'(ack_q.size()), 32'd0);

        // Spurious ACK while idle.
        force_ack = 1;
        tick();
        force_ack = 0;
        bad = 0;
        repeat (4) begin
            tick();
            if (RDY_client_response_get || CYC_O) bad = 1;
        end
        chk("spurious_ack", 32'(bad), 32'd0);
        chk("spurious_rdy_put", 32'(RDY_client_request_put), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got=running expected=finished");
        $fatal(1);
    end
endmodule
